// File: rtl/clk_sched_pkg.sv
// Shared constants, rate-table helper and scheduler state type for the
// runtime-selectable clock generator.
package clk_sched_pkg;

   localparam int unsigned RATE_W    = 3;
   localparam int unsigned NUM_RATES = 8;

   function automatic int unsigned half_count(input int unsigned base,
                                              input int unsigned step,
                                              input int unsigned idx);
      int unsigned h;
      h = base;
      for (int unsigned i = 0; i < idx; i++) h = h * step;
      return h;
   endfunction

   function automatic int unsigned ctr_width(input int unsigned base,
                                             input int unsigned step);
      int unsigned m;
      m = half_count(base, step, NUM_RATES - 1);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   localparam int unsigned CTR_W = ctr_width(5, 10);

   typedef enum logic {RUN, PEND} sched_state_t;

endpackage

// File: rtl/clk_sched_divider.sv
// Half-period counter and square-wave toggle; flags the rising and falling
// toggle cycles so the scheduler can align rate changes.
module clk_sched_divider
   import clk_sched_pkg::*;
#(
   parameter int unsigned CW = CTR_W
) (
   input  logic          CLK100MHZ,
   input  logic          reset,
   input  logic [CW-1:0] half_cnt,
   input  logic          apply_new,
   output logic          clk_out,
   output logic          rise,
   output logic          fall
);

   logic [CW-1:0] ctr;
   logic          terminal;

   assign terminal = (ctr == half_cnt - CW'(1));
   assign rise     = terminal & ~clk_out;
   assign fall     = terminal & clk_out;

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         ctr     <= '0;
         clk_out <= 1'b0;
      end else begin
         if (terminal || apply_new) ctr <= '0;
         else                       ctr <= ctr + CW'(1);
         if (terminal) clk_out <= ~clk_out;
      end
   end

endmodule

// File: rtl/clk_rate_scheduler.sv
// Runtime-selectable decade clock generator: manual rate requests and an
// automatic sweep, both applied only at the falling toggle of clk_out.
module clk_rate_scheduler
   import clk_sched_pkg::*;
#(
   parameter int unsigned HALF_BASE     = 5,
   parameter int unsigned RATE_STEP     = 10,
   parameter int unsigned DEFAULT_IDX   = 4,
   parameter int unsigned DWELL_PERIODS = 4
) (
   input  logic       CLK100MHZ,
   input  logic       reset,
   input  logic [2:0] sel,
   input  logic       sel_load,
   input  logic       sweep_en,
   output logic       clk_out,
   output logic       tick,
   output logic [2:0] rate_idx,
   output logic       busy
);

   localparam int unsigned CW = ctr_width(HALF_BASE, RATE_STEP);
   localparam int unsigned DW = (DWELL_PERIODS > 1) ? $clog2(DWELL_PERIODS) : 1;

   logic [CW-1:0] half_tbl [NUM_RATES];
   logic [CW-1:0] half_cnt;
   logic          rise, fall, apply_new;
   sched_state_t  state, state_n;
   logic [2:0]    pend_idx, pend_n, rate_n;
   logic [DW-1:0] dwell, dwell_n;

   for (genvar g = 0; g < NUM_RATES; g++) begin : g_half
      assign half_tbl[g] = CW'(half_count(HALF_BASE, RATE_STEP, g));
   end

   assign half_cnt = half_tbl[rate_idx];
   assign busy     = (state == PEND);

   clk_sched_divider #(.CW(CW)) u_div (
      .CLK100MHZ (CLK100MHZ),
      .reset     (reset),
      .half_cnt  (half_cnt),
      .apply_new (apply_new),
      .clk_out   (clk_out),
      .rise      (rise),
      .fall      (fall)
   );

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         state    <= RUN;
         pend_idx <= '0;
         rate_idx <= 3'(DEFAULT_IDX);
         dwell    <= '0;
         tick     <= 1'b0;
      end else begin
         state    <= state_n;
         pend_idx <= pend_n;
         rate_idx <= rate_n;
         dwell    <= dwell_n;
         tick     <= rise;
      end
   end

   // A request arriving on a sweep-advance boundary is still captured into PEND.
   always_comb begin
      state_n   = state;
      pend_n    = pend_idx;
      rate_n    = rate_idx;
      dwell_n   = dwell;
      apply_new = 1'b0;
      case (state)
         RUN: begin
            if (!sweep_en) begin
               dwell_n = '0;
            end else if (fall) begin
               if (dwell == DW'(DWELL_PERIODS - 1)) begin
                  rate_n    = rate_idx + 3'd1;
                  dwell_n   = '0;
                  apply_new = 1'b1;
               end else begin
                  dwell_n = dwell + DW'(1);
               end
            end
            if (sel_load) begin
               pend_n  = sel;
               state_n = PEND;
            end
         end
         PEND: begin
            if (fall) begin
               rate_n    = pend_idx;
               dwell_n   = '0;
               state_n   = RUN;
               apply_new = 1'b1;
            end
         end
         default: state_n = RUN;
      endcase
   end

endmodule

// File: tb/tb_clk_rate_scheduler.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs of two
// differently parameterised instances; directed checks cover the named scenarios.
module tb_clk_rate_scheduler;

   logic       clk;
   logic       rst_a, load_a, sweep_a, rst_b, load_b, sweep_b;
   logic [2:0] sel_a, sel_b;
   logic       clk_out_a, tick_a, busy_a, clk_out_b, tick_b, busy_b;
   logic [2:0] rate_a, rate_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   clk_rate_scheduler #(.HALF_BASE(5), .RATE_STEP(10), .DEFAULT_IDX(0), .DWELL_PERIODS(4)) u_dut_a (
      .CLK100MHZ(clk), .reset(rst_a), .sel(sel_a), .sel_load(load_a), .sweep_en(sweep_a),
      .clk_out(clk_out_a), .tick(tick_a), .rate_idx(rate_a), .busy(busy_a));

   clk_rate_scheduler #(.HALF_BASE(1), .RATE_STEP(2), .DEFAULT_IDX(6), .DWELL_PERIODS(2)) u_dut_b (
      .CLK100MHZ(clk), .reset(rst_b), .sel(sel_b), .sel_load(load_b), .sweep_en(sweep_b),
      .clk_out(clk_out_b), .tick(tick_b), .rate_idx(rate_b), .busy(busy_b));

   typedef struct {
      int ctr; bit clk; bit tick; int idx; bit pst; int pend; int dwell;
   } mdl_t;

   mdl_t mA, mB;
   logic [5:0] exp_a_q[$], exp_b_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int mhalf(input int hb, input int st, input int idx);
      int h;
      h = hb;
      for (int i = 0; i < idx; i++) h = h * st;
      return h;
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input bit rst, input int sel, input bit load,
                                  input bit sweep, input int hb, input int st, input int dp,
                                  input int didx);
      mdl_t n;
      int   half;
      bit   bnd;
      n = m;
      if (rst) begin
         n = '{ctr:0, clk:0, tick:0, idx:didx, pst:0, pend:0, dwell:0};
         return n;
      end
      half   = mhalf(hb, st, m.idx);
      bnd    = (m.ctr == half - 1) && m.clk;
      n.tick = (m.ctr == half - 1) && !m.clk;
      if (m.ctr == half - 1) begin
         n.ctr = 0;
         n.clk = !m.clk;
      end else begin
         n.ctr = m.ctr + 1;
      end
      if (m.pst) begin
         if (bnd) begin
            n.idx = m.pend; n.pst = 0; n.dwell = 0;
         end
      end else begin
         if (!sweep) n.dwell = 0;
         else if (bnd) begin
            if (m.dwell == dp - 1) begin
               n.idx = (m.idx + 1) % 8; n.dwell = 0;
            end else begin
               n.dwell = m.dwell + 1;
            end
         end
         if (load) begin
            n.pst = 1; n.pend = sel;
         end
      end
      return n;
   endfunction

   function automatic logic [5:0] pack(input mdl_t m);
      logic [2:0] i3;
      i3 = 3'(m.idx);
      return {m.clk, m.tick, i3, m.pst};
   endfunction

   task automatic cycle();
      mA = mstep(mA, rst_a, int'(sel_a), load_a, sweep_a, 5, 10, 4, 0);
      exp_a_q.push_back(pack(mA));
      mB = mstep(mB, rst_b, int'(sel_b), load_b, sweep_b, 1, 2, 2, 6);
      exp_b_q.push_back(pack(mB));
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_a_q.size() > 0) chk("cycle_a", {clk_out_a, tick_a, rate_a, busy_a}, exp_a_q.pop_front());
      if (exp_b_q.size() > 0) chk("cycle_b", {clk_out_b, tick_b, rate_b, busy_b}, exp_b_q.pop_front());
   end

   task automatic wait_tick(input bit on_b, input int bound, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (((on_b ? tick_b : tick_a) !== 1'b1) && n < bound);
   endtask

   task automatic wait_rate(input bit on_b, input logic [2:0] target, input int bound, input string tag);
      int n;
      n = 0;
      while (((on_b ? rate_b : rate_a) !== target) && n < bound) begin
         cycle();
         n++;
      end
      chk(tag, on_b ? rate_b : rate_a, target);
   endtask

   int n;
   int k;
   int ivl_exp  [6] = '{64, 128, 192, 256, 129, 2};
   int rate_exp [6] = '{6, 6, 7, 7, 0, 0};

   initial begin
      mA = '{default: 0};
      mB = '{default: 0};
      rst_a = 1; load_a = 0; sweep_a = 0; sel_a = 0;
      rst_b = 1; load_b = 0; sweep_b = 1; sel_b = 0;
      #2;
      cycle(); cycle();
      chk("reset_clk_a", clk_out_a, 0);
      chk("reset_busy_a", busy_a, 0);
      rst_a = 0;

      // basic divide at idx0: first tick after 5, then every 10
      wait_tick(0, 100, n); chk("t1_first_tick", n, 5);
      wait_tick(0, 100, n); chk("t1_period", n, 10);
      wait_tick(0, 100, n); chk("t1_period2", n, 10);

      // manual switch to 1 in the high phase; a second request is ignored
      sel_a = 1; load_a = 1; cycle(); load_a = 0;
      chk("t2_busy", busy_a, 1);
      sel_a = 3; load_a = 1; cycle(); load_a = 0;
      chk("t3_busy_held", busy_a, 1);
      wait_rate(0, 3'd1, 50, "t2_rate");
      chk("t2_busy_clear", busy_a, 0);
      wait_tick(0, 300, n); chk("t2_low_half", n, 50);
      wait_tick(0, 300, n); chk("t2_period", n, 100);
      chk("t3_rate_not3", rate_a, 1);

      // reset while a switch to 2 is pending
      rst_a = 1; cycle(); rst_a = 0;
      wait_tick(0, 100, n); chk("t5_pre_tick", n, 5);
      sel_a = 2; load_a = 1; cycle(); load_a = 0;
      chk("t5_busy", busy_a, 1);
      rst_a = 1; cycle(); rst_a = 0;
      chk("t5_busy_rst", busy_a, 0);
      chk("t5_rate_rst", rate_a, 0);
      chk("t5_clk_rst", clk_out_a, 0);
      repeat (200) cycle();
      chk("t5_no_switch", rate_a, 0);

      // sweep 6 -> 7 -> wrap to 0 with two periods per rate
      rst_b = 0;
      for (int i = 0; i < 6; i++) begin
         wait_tick(1, 600, n);
         chk("t4_interval", n, ivl_exp[i]);
         chk("t4_rate", rate_b, rate_exp[i]);
      end

      // request on the same boundary as the 2->3 sweep advance
      k = 0;
      while (!(!mB.pst && mB.idx == 2 && mB.dwell == 1 && mB.clk &&
               mB.ctr == mhalf(1, 2, 2) - 1) && k < 2000) begin
         cycle();
         k++;
      end
      chk("t6_at_idx2", rate_b, 2);
      sel_b = 5; load_b = 1; cycle(); load_b = 0;
      chk("t6_rate3", rate_b, 3);
      chk("t6_busy", busy_b, 1);
      wait_rate(1, 3'd5, 100, "t6_rate5");
      chk("t6_busy_clear", busy_b, 0);
      wait_rate(1, 3'd6, 400, "t6_sweep_resume");

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
